serial_adder_seq: RTL and testbench
===================================

# serial_adder_seq

Sequencer for the bit-serial adder datapath. On a host `start` it runs one frame in fixed phases: shift DATA_WIDTH operand bits into the input shift registers, let the adder compute, capture the result into the output shift register, then shift DATA_WIDTH result bits out. It produces the datapath enables and a busy/done handshake to the host, and sits beside the shift registers and the adder at the top level.

## Interface

One clock; reset is asynchronous and active-high.

Parameters:
- DATA_WIDTH, 32: operand/result width in bits; must be ≥ 2.
- ADD_LATENCY, 2: adder compute cycles between load and capture; 0 is legal.
- CNT_W, derived as $clog2(DATA_WIDTH) (min 1): width of the bit counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous reset, active-high (1 = reset asserted).
- start  in  1  frame request, level-sampled; accepted only in IDLE or DONE.
- abort  in  1  cancels any frame in progress.
- busy  out  1  high in LOAD, COMPUTE, CAPTURE and UNLOAD.
- done  out  1  one-cycle pulse in DONE after a completed frame.
- shift_in_en  out  1  input shift registers shift one bit; high in LOAD only.
- add_en  out  1  adder operands valid; high in COMPUTE only.
- out_load  out  1  output register parallel-loads the sum; high in CAPTURE only.
- shift_out_en  out  1  output register shifts one bit; high in UNLOAD only.
- bit_idx  out  CNT_W  current bit index in LOAD/UNLOAD; 0 in all other states.

## Operation

- Each state drives exactly one of `shift_in_en`, `add_en`, `out_load`, `shift_out_en`, `done`, or none (IDLE).
- FSM transitions:
  - IDLE → LOAD on `start`.
  - LOAD → COMPUTE after DATA_WIDTH cycles. If ADD_LATENCY = 0, go straight to CAPTURE.
  - COMPUTE → CAPTURE after ADD_LATENCY cycles.
  - CAPTURE → UNLOAD after 1 cycle.
  - UNLOAD → DONE after DATA_WIDTH cycles.
  - DONE → LOAD if `start` is high, otherwise → IDLE. This gives back-to-back frames with no idle gap.
- Bit counter:
  - Counts 0..DATA_WIDTH-1 in LOAD and again in UNLOAD.
  - Clears on every phase change.
  - Also reused to count COMPUTE cycles.
  - The terminal compare is `cnt == DATA_WIDTH-1` (or `ADD_LATENCY-1`).
  - The counter never wraps past its terminal value.
- `start` is ignored in LOAD, COMPUTE, CAPTURE and UNLOAD. It is not queued.
- Abort:
  - `abort` in any state other than IDLE → IDLE on the next edge. All strobes drop and no `done` is issued.
  - `abort` together with `start` in IDLE or DONE → IDLE. Abort wins.
  - `abort` in DONE suppresses the back-to-back restart; `done` is still high for that cycle.
- Reset, including mid-frame: state = IDLE, counter = 0, all outputs 0 asynchronously. The first frame after release needs a fresh `start`.

## Timing

- Cycle 0 is the edge at which `start` is sampled in IDLE. For a frame of DATA_WIDTH = W and ADD_LATENCY = L:
  - LOAD: cycles 1..W
  - COMPUTE: cycles W+1..W+L
  - CAPTURE: cycle W+L+1
  - UNLOAD: cycles W+L+2..2W+L+1
  - DONE: cycle 2W+L+2
- Frame length is 2W+L+2 cycles. With back-to-back restart, the period is 2W+L+2 cycles.
- All outputs are registered, decoded from state with no combinational path from inputs. `abort` therefore takes effect one cycle after it is sampled.
- `bit_idx` equals the counter value in the same cycle as its enable.

## Structure

- Shared package `serial_seq_pkg` holds:
  - State enum: IDLE, LOAD, COMPUTE, CAPTURE, UNLOAD, DONE.
  - The CNT_W derivation function.
  - Default DATA_WIDTH and ADD_LATENCY constants used by the top level.
- One sub-module, `phase_counter`:
  - Inputs: clear, enable, terminal value.
  - Outputs: count and a `last` flag.
  - Async active-high reset.
- The FSM and output decode stay in `serial_adder_seq`.

## Test plan

- Reset then idle: hold `resetn` = 1, then release. All outputs stay 0 and `busy` = 0 for 10 cycles with `start` = 0.
- Single frame, W = 32, L = 2, `start` pulsed at cycle 0:
  - `shift_in_en` high for cycles 1–32, with `bit_idx` running 0..31.
  - `add_en` high for cycles 33–34.
  - `out_load` high at cycle 35.
  - `shift_out_en` high for cycles 36–67.
  - `done` high at cycle 68.
  - `busy` high for cycles 1–67.
- Back-to-back: `start` held high continuously. `done` pulses at cycles 68 and 136, and LOAD restarts at cycle 69.
- Ignored start and abort:
  - `start` pulsed at cycle 10 of LOAD leaves timing unchanged.
  - `abort` at cycle 40 returns to IDLE at cycle 41, with no `done` and all strobes 0.
  - `abort` and `start` together in IDLE keep the block in IDLE.
- Mid-frame reset: assert `resetn` during UNLOAD (cycle 50). All outputs drop immediately, and the block stays in IDLE after release until a new `start`.
- ADD_LATENCY = 0, W = 4, `start` at cycle 0:
  - LOAD cycles 1–4.
  - CAPTURE cycle 5.
  - UNLOAD cycles 6–9.
  - `done` at cycle 10.
  - `add_en` never asserted.

Source files
------------

// File: rtl/serial_seq_pkg.sv
// serial_seq_pkg: shared state encoding, counter width helper and default sizing for the serial adder sequencer
package serial_seq_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADD_LATENCY = 2;

    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/serial_adder_seq_if.sv
// serial_adder_seq_if: host handshake and datapath strobes of the serial adder sequencer
// master: drives start/abort, observes status and strobes; slave: the sequencer side
interface serial_adder_seq_if #(
    parameter int CNT_W = serial_seq_pkg::cnt_w(serial_seq_pkg::DEF_DATA_WIDTH)
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             shift_in_en;
    logic             add_en;
    logic             out_load;
    logic             shift_out_en;
    logic [CNT_W-1:0] bit_idx;

    modport master (
        output start, abort,
        input  busy, done, shift_in_en, add_en, out_load, shift_out_en, bit_idx
    );

    modport slave (
        input  start, abort,
        output busy, done, shift_in_en, add_en, out_load, shift_out_en, bit_idx
    );
endinterface

// File: rtl/phase_counter.sv
// phase_counter: saturating phase counter with clear, enable and terminal flag
// ports: clk, resetn (async, active-high), clear, en, term -> cnt, last (cnt == term)
module phase_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);
    assign last = cnt == term;

    // holds at the terminal value instead of wrapping
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en && !last) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: frame sequencer for the bit-serial adder (load, compute, capture, unload)
// ports: clk, resetn (async, active-high), bus (slave: start/abort in; busy, done, strobes, bit_idx out)
module serial_adder_seq
    import serial_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADD_LATENCY = DEF_ADD_LATENCY
) (
    input  logic               clk,
    input  logic               resetn,
    serial_adder_seq_if.slave  bus
);
    localparam int CNT_W = cnt_w(DATA_WIDTH);
    localparam logic [CNT_W-1:0] W_TERM = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] L_TERM = CNT_W'(ADD_LATENCY > 0 ? ADD_LATENCY - 1 : 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;

    always_comb begin
        state_nxt = state;
        if (bus.abort) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    state_nxt = bus.start ? LOAD : IDLE;
                LOAD:    state_nxt = last ? (ADD_LATENCY == 0 ? CAPTURE : COMPUTE) : LOAD;
                COMPUTE: state_nxt = last ? CAPTURE : COMPUTE;
                CAPTURE: state_nxt = UNLOAD;
                UNLOAD:  state_nxt = last ? DONE : UNLOAD;
                DONE:    state_nxt = bus.start ? LOAD : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state <= IDLE;
        else state <= state_nxt;
    end

    // one counter serves every phase; it restarts from zero on each phase change
    phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state_nxt != state),
        .en     (state == LOAD || state == COMPUTE || state == UNLOAD),
        .term   (state == COMPUTE ? L_TERM : W_TERM),
        .cnt    (cnt),
        .last   (last)
    );

    assign bus.busy         = state == LOAD || state == COMPUTE || state == CAPTURE || state == UNLOAD;
    assign bus.done         = state == DONE;
    assign bus.shift_in_en  = state == LOAD;
    assign bus.add_en       = state == COMPUTE;
    assign bus.out_load     = state == CAPTURE;
    assign bus.shift_out_en = state == UNLOAD;
    assign bus.bit_idx      = (state == LOAD || state == UNLOAD) ? cnt : '0;
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: table-driven scoreboard bench for serial_adder_seq at (W=32,L=2) and (W=4,L=0)
module tb_serial_adder_seq;
    typedef struct {
        string name;
        int    sel;
        int    n;
        int    s0;
        int    s1;
        int    a;
        int    x;
    } scen_t;

    typedef struct {
        string       name;
        int          cyc;
        logic [10:0] v;
    } exp_t;

    logic  clk = 1'b0;
    logic  resetn;
    int    checks = 0;
    int    failures = 0;
    int    kk[2] = '{0, 0};
    int    ws[2] = '{32, 4};
    int    ls[2] = '{2, 0};
    exp_t  sbq[$];
    scen_t tbl[9];

    always #5 clk = ~clk;

    serial_adder_seq_if #(.CNT_W(5)) a_if ();
    serial_adder_seq_if #(.CNT_W(2)) b_if ();

    serial_adder_seq #(.DATA_WIDTH(32), .ADD_LATENCY(2)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (a_if)
    );

    serial_adder_seq #(.DATA_WIDTH(4), .ADD_LATENCY(0)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (b_if)
    );

    function automatic logic [10:0] obs(input int sel);
        return (sel == 0)
            ? {a_if.busy, a_if.done, a_if.shift_in_en, a_if.add_en, a_if.out_load, a_if.shift_out_en, a_if.bit_idx}
            : {b_if.busy, b_if.done, b_if.shift_in_en, b_if.add_en, b_if.out_load, b_if.shift_out_en, 3'b000, b_if.bit_idx};
    endfunction

    // expected outputs at offset k within a frame (k = 0 means idle), from the frame timing table
    function automatic logic [10:0] expv(input int w, input int l, input int k);
        logic [4:0] b;
        logic bs, dn, si, ad, ol, so;
        si = k >= 1 && k <= w;
        ad = k > w && k <= w + l;
        ol = k == w + l + 1;
        so = k >= w + l + 2 && k <= 2 * w + l + 1;
        dn = k == 2 * w + l + 2;
        bs = k >= 1 && k <= 2 * w + l + 1;
        b = 5'd0;
        if (si) b = 5'(k - 1);
        if (so) b = 5'(k - w - l - 2);
        return {bs, dn, si, ad, ol, so, b};
    endfunction

    task automatic check(input string nm, input int cyc, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got busy,done,sin,add,oload,sout,idx=%b want=%b", nm, cyc, got, want);
        end
    endtask

    task automatic step(input int sel, input logic st, input logic ab, input string nm, input int cyc);
        exp_t e;
        int f;
        @(negedge clk);
        a_if.start = (sel == 0) && st;
        a_if.abort = (sel == 0) && ab;
        b_if.start = (sel == 1) && st;
        b_if.abort = (sel == 1) && ab;
        f = 2 * ws[sel] + ls[sel] + 2;
        if (ab) kk[sel] = 0;
        else if (kk[sel] == 0 || kk[sel] == f) kk[sel] = st ? 1 : 0;
        else kk[sel]++;
        e.name = nm;
        e.cyc = cyc;
        e.v = expv(ws[sel], ls[sel], kk[sel]);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check(e.name, e.cyc, obs(sel), e.v);
    endtask

    task automatic run(input scen_t s);
        for (int c = 0; c < s.n; c++)
            step(s.sel, (c >= s.s0 && c <= s.s1) || c == s.x, c == s.a, s.name, c + 1);
    endtask

    initial begin
        resetn = 1'b0;
        a_if.start = 1'b0;
        a_if.abort = 1'b0;
        b_if.start = 1'b0;
        b_if.abort = 1'b0;
        #1 resetn = 1'b1;
        #1;
        check("reset_a", 0, obs(0), 11'd0);
        check("reset_b", 0, obs(1), 11'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;

        tbl = '{
            '{"idle",       0,  10, -1,  -2, -1, -1},
            '{"single",     0,  72,  0,   0, -1, -1},
            '{"b2b",        0, 140,  0, 135, -1, -1},
            '{"ign_start",  0,  70,  0,   0, -1, 10},
            '{"abort40",    0,  45,  0,   0, 40, -1},
            '{"abort_idle", 0,   5,  0,   0,  0, -1},
            '{"abort_done", 0,  72,  0,  68, 68, -1},
            '{"lat0",       1,  12,  0,   0, -1, -1},
            '{"lat0_b2b",   1,  24,  0,  19, -1, -1}
        };
        foreach (tbl[i]) run(tbl[i]);

        // reset asserted mid-UNLOAD must clear outputs without waiting for a clock edge
        step(0, 1'b1, 1'b0, "rst_mid", 1);
        for (int c = 1; c < 50; c++) step(0, 1'b0, 1'b0, "rst_mid", c + 1);
        @(negedge clk);
        #2 resetn = 1'b1;
        kk = '{0, 0};
        #1;
        check("rst_async", 50, obs(0), 11'd0);
        @(posedge clk);
        #1;
        check("rst_hold", 51, obs(0), 11'd0);
        @(negedge clk);
        resetn = 1'b0;
        for (int c = 0; c < 5; c++) step(0, 1'b0, 1'b0, "rst_after", c + 1);
        run('{"rst_fresh", 0, 70, 0, 0, -1, -1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
